pixel_stream_tx: RTL and testbench

//  Raster-scan pixel source; the transmit end of the pixel-byte stream consumed by the x accumulator.

---
 rtl/nav_pkg.sv | 30 +++
 rtl/pix_skid_buf.sv | 52 +++++
 rtl/pixel_stream_tx.sv | 233 +++++++++++++++++++++++
 tb/tb_pixel_stream_tx.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nav_pkg.sv
// Shared types for the pixel-stream transmitter: FSM states, the beat payload
// carried through the skid buffer, and a width helper.
package nav_pkg;

    localparam int unsigned PIX_W_DEF = 8;
    localparam int unsigned XY_W      = 16;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRead   = 2'd1,
        StHblank = 2'd2,
        StDrain  = 2'd3
    } tx_state_t;

    typedef struct packed {
        logic [PIX_W_DEF-1:0] data;
        logic [XY_W-1:0]      x;
        logic [XY_W-1:0]      y;
        logic                 sol;
        logic                 eol;
        logic                 sof;
        logic                 eof;
    } pix_beat_t;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pix_skid_buf.sv
// Two-entry FIFO holding pixel beats between the RAM return path and the sink.
// Head entry drives the output directly so held outputs are register-stable.
module pix_skid_buf
    import nav_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    input  pix_beat_t  i_in_beat,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output pix_beat_t  o_out_beat,
    output logic [1:0] o_count
);

    pix_beat_t  r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic       w_push;
    logic       w_pop;

    always_comb begin
        o_in_ready  = (r_count != 2'd2);
        o_out_valid = (r_count != 2'd0);
        o_out_beat  = r_mem[r_rd_ptr];
        o_count     = r_count;
        w_push      = i_in_valid & o_in_ready;
        w_pop       = o_out_valid & i_out_ready;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_in_beat;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/pixel_stream_tx.sv
// Raster-scan pixel source: reads a frame buffer row-major and streams beats with markers.
// Define TEST_PATTERN_EN to replace RAM data with an x^y pattern (mem_rd_en held low).
module pixel_stream_tx
    import nav_pkg::*;
#(
    parameter int unsigned IMG_W  = 64,
    parameter int unsigned IMG_H  = 48,
    parameter int unsigned PIX_W  = PIX_W_DEF,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned HBLANK = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [PIX_W-1:0]  i_mem_rd_data,
    output logic              o_pix_valid,
    input  logic              i_pix_ready,
    output logic [PIX_W-1:0]  o_pix_data,
    output logic [15:0]       o_pix_x,
    output logic [15:0]       o_pix_y,
    output logic              o_pix_sof,
    output logic              o_pix_eof,
    output logic              o_pix_sol,
    output logic              o_pix_eol
);

    localparam int unsigned XW     = clog2_min1(IMG_W);
    localparam int unsigned YW     = clog2_min1(IMG_H);
    localparam int unsigned HW     = clog2_min1(HBLANK + 1);
    localparam int unsigned BEAT_W = PIX_W_DEF;

    tx_state_t         r_state;
    tx_state_t         w_state_next;
    logic [XW-1:0]     r_rd_x;
    logic [YW-1:0]     r_rd_y;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [HW-1:0]     r_hb_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_inflight;
    logic [XY_W-1:0]   r_inf_x;
    logic [XY_W-1:0]   r_inf_y;
    logic              r_inf_sol;
    logic              r_inf_eol;
    logic              r_inf_sof;
    logic              r_inf_eof;

    logic              w_issue;
    logic              w_x_last;
    logic              w_y_last;
    logic              w_hb_end;
    logic              w_pop;
    logic              w_last_pop;
    logic              w_push;
    logic              w_in_ready;
    logic              w_out_valid;
    logic [1:0]        w_count;
    logic [2:0]        w_occ;
    logic [2:0]        w_cap;
    pix_beat_t         w_in_beat;
    pix_beat_t         w_out_beat;

    always_comb begin
        w_x_last = (r_rd_x == XW'(IMG_W - 1));
        w_y_last = (r_rd_y == YW'(IMG_H - 1));
        w_hb_end = (r_hb_cnt == HW'(HBLANK - 1));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next = StRead;
                end
            end
            StRead: begin
                if (w_issue && w_x_last) begin
                    if (w_y_last) begin
                        w_state_next = StDrain;
                    end else if (HBLANK == 0) begin
                        w_state_next = StRead;
                    end else begin
                        w_state_next = StHblank;
                    end
                end
            end
            StHblank: begin
                if (w_hb_end) begin
                    w_state_next = StRead;
                end
            end
            StDrain: begin
                if (w_last_pop) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // A read may issue when the slot it needs is guaranteed free by the time data returns;
    // a handshake this cycle frees one slot, which sustains one pixel per cycle.
    always_comb begin
        w_pop       = w_out_valid & i_pix_ready;
        w_occ       = {1'b0, w_count} + {2'b00, r_inflight};
        w_cap       = 3'd2 + {2'b00, w_pop};
        w_issue     = (r_state == StRead) && (w_occ < w_cap);
        w_last_pop  = (r_state == StDrain) && w_pop && !r_inflight && (w_count == 2'd1);
        w_push      = r_inflight & w_in_ready;
`ifdef TEST_PATTERN_EN
        o_mem_rd_en = 1'b0;
`else
        o_mem_rd_en = w_issue;
`endif
        o_mem_addr  = r_mem_addr;
        o_busy      = r_busy;
        o_done      = r_done;
        o_pix_valid = w_out_valid;
        o_pix_data  = PIX_W'(w_out_beat.data);
        o_pix_x     = w_out_beat.x;
        o_pix_y     = w_out_beat.y;
        o_pix_sol   = w_out_beat.sol;
        o_pix_eol   = w_out_beat.eol;
        o_pix_sof   = w_out_beat.sof;
        o_pix_eof   = w_out_beat.eof;
    end

    always_comb begin
        w_in_beat     = '0;
        w_in_beat.x   = r_inf_x;
        w_in_beat.y   = r_inf_y;
        w_in_beat.sol = r_inf_sol;
        w_in_beat.eol = r_inf_eol;
        w_in_beat.sof = r_inf_sof;
        w_in_beat.eof = r_inf_eof;
`ifdef TEST_PATTERN_EN
        w_in_beat.data = BEAT_W'(r_inf_x[7:0] ^ r_inf_y[7:0]);
`else
        w_in_beat.data = BEAT_W'(i_mem_rd_data);
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_x     <= '0;
            r_rd_y     <= '0;
            r_mem_addr <= '0;
            r_hb_cnt   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_inflight <= 1'b0;
            r_inf_x    <= '0;
            r_inf_y    <= '0;
            r_inf_sol  <= 1'b0;
            r_inf_eol  <= 1'b0;
            r_inf_sof  <= 1'b0;
            r_inf_eof  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_done     <= w_last_pop;
            // Coordinates and markers ride alongside the read so they meet its data.
            if (w_issue) begin
                r_inf_x   <= XY_W'(r_rd_x);
                r_inf_y   <= XY_W'(r_rd_y);
                r_inf_sol <= (r_rd_x == '0);
                r_inf_eol <= w_x_last;
                r_inf_sof <= (r_rd_x == '0) && (r_rd_y == '0);
                r_inf_eof <= w_x_last && w_y_last;
            end
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_rd_x     <= '0;
                        r_rd_y     <= '0;
                        r_mem_addr <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                StRead: begin
                    if (w_issue) begin
                        r_mem_addr <= r_mem_addr + ADDR_W'(1);
                        r_hb_cnt   <= '0;
                        if (!w_x_last) begin
                            r_rd_x <= r_rd_x + XW'(1);
                        end else if (!w_y_last && HBLANK == 0) begin
                            r_rd_x <= '0;
                            r_rd_y <= r_rd_y + YW'(1);
                        end
                    end
                end
                StHblank: begin
                    r_hb_cnt <= r_hb_cnt + HW'(1);
                    if (w_hb_end) begin
                        r_rd_x <= '0;
                        r_rd_y <= r_rd_y + YW'(1);
                    end
                end
                StDrain: begin
                    if (w_last_pop) begin
                        r_busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    pix_skid_buf u_skid (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_in_valid  (w_push),
        .o_in_ready  (w_in_ready),
        .i_in_beat   (w_in_beat),
        .o_out_valid (w_out_valid),
        .i_out_ready (i_pix_ready),
        .o_out_beat  (w_out_beat),
        .o_count     (w_count)
    );

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Bench for pixel_stream_tx: a 4x2 instance for directed scenarios and a 64x48 instance
// driven with random backpressure; expected beats come from a raster-order model.
module tb_pixel_stream_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [7:0]  d;
        logic [15:0] x;
        logic [15:0] y;
        logic        sol;
        logic        eol;
        logic        sof;
        logic        eof;
    } beat_t;

    // Small instance: 4x2, 2 blanking cycles
    logic        s_rst, s_start, s_busy, s_done, s_rd_en, s_ready, s_valid;
    logic        s_sof, s_eof, s_sol, s_eol;
    logic [11:0] s_addr;
    logic [7:0]  s_rd_data, s_data;
    logic [15:0] s_x, s_y;

    // Large instance: 64x48, 4 blanking cycles
    logic        l_rst, l_start, l_busy, l_done, l_rd_en, l_ready, l_valid;
    logic        l_sof, l_eof, l_sol, l_eol;
    logic [11:0] l_addr;
    logic [7:0]  l_rd_data, l_data;
    logic [15:0] l_x, l_y;

    pixel_stream_tx #(.IMG_W(4), .IMG_H(2), .PIX_W(8), .ADDR_W(12), .HBLANK(2)) dut_s (
        .i_clk(clk), .i_rst(s_rst), .i_start(s_start), .o_busy(s_busy), .o_done(s_done),
        .o_mem_rd_en(s_rd_en), .o_mem_addr(s_addr), .i_mem_rd_data(s_rd_data),
        .o_pix_valid(s_valid), .i_pix_ready(s_ready), .o_pix_data(s_data),
        .o_pix_x(s_x), .o_pix_y(s_y), .o_pix_sof(s_sof), .o_pix_eof(s_eof),
        .o_pix_sol(s_sol), .o_pix_eol(s_eol)
    );

    pixel_stream_tx #(.IMG_W(64), .IMG_H(48), .PIX_W(8), .ADDR_W(12), .HBLANK(4)) dut_l (
        .i_clk(clk), .i_rst(l_rst), .i_start(l_start), .o_busy(l_busy), .o_done(l_done),
        .o_mem_rd_en(l_rd_en), .o_mem_addr(l_addr), .i_mem_rd_data(l_rd_data),
        .o_pix_valid(l_valid), .i_pix_ready(l_ready), .o_pix_data(l_data),
        .o_pix_x(l_x), .o_pix_y(l_y), .o_pix_sof(l_sof), .o_pix_eof(l_eof),
        .o_pix_sol(l_sol), .o_pix_eol(l_eol)
    );

    // Frame-buffer RAMs holding RAM[i] = i (low 8 bits)
    always @(posedge clk) begin
        if (s_rd_en) s_rd_data <= s_addr[7:0];
        if (l_rd_en) l_rd_data <= l_addr[7:0];
    end

    beat_t s_beats[$];
    int    s_rd_cyc[$];
    int    s_rd_addr[$];
    int    s_done_cyc[$];
    beat_t l_beats[$];
    int    l_done_n = 0;
    int    l_hold_viol = 0;
    logic        l_prev_stall = 1'b0;
    logic [43:0] l_prev_out;

    always @(negedge clk) begin
        if (s_valid && s_ready)
            s_beats.push_back('{cyc, s_data, s_x, s_y, s_sol, s_eol, s_sof, s_eof});
        if (s_rd_en) begin
            s_rd_cyc.push_back(cyc);
            s_rd_addr.push_back(int'(s_addr));
        end
        if (s_done) s_done_cyc.push_back(cyc);
    end

    always @(negedge clk) begin
        if (l_prev_stall &&
            (!l_valid || {l_data, l_x, l_y, l_sol, l_eol, l_sof, l_eof} !== l_prev_out))
            l_hold_viol++;
        l_prev_stall = l_valid && !l_ready;
        l_prev_out   = {l_data, l_x, l_y, l_sol, l_eol, l_sof, l_eof};
        if (l_valid && l_ready)
            l_beats.push_back('{cyc, l_data, l_x, l_y, l_sol, l_eol, l_sof, l_eof});
        if (l_done) l_done_n++;
    end

    // Reference: beat k of a w*h raster frame
    function automatic logic [7:0] exp_pix(input int w, input int k);
        int x = k % w;
        int y = k / w;
`ifdef TEST_PATTERN_EN
        return 8'(x ^ y);
`else
        if (y < 0) return 8'(x);
        return 8'(k);
`endif
    endfunction

    function automatic logic [43:0] exp_beat(input int w, input int h, input int k);
        int x = k % w;
        int y = k / w;
        return {exp_pix(w, k), 16'(x), 16'(y), x == 0, x == w - 1, k == 0, k == w * h - 1};
    endfunction

    function automatic logic [43:0] pack_beat(input beat_t b);
        return {b.d, b.x, b.y, b.sol, b.eol, b.sof, b.eof};
    endfunction

    task automatic s_clear();
        s_beats.delete();
        s_rd_cyc.delete();
        s_rd_addr.delete();
        s_done_cyc.delete();
    endtask

    task automatic s_pulse_start();
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
    endtask

    task automatic s_wait_done(input int budget);
        int n = 0;
        while (s_done_cyc.size() == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        s_rst = 1'b1; l_rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({s_busy, s_done, s_rd_en, s_valid, s_sof, s_eof, s_sol, s_eol} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctl got %b want 00000000",
                     {s_busy, s_done, s_rd_en, s_valid, s_sof, s_eof, s_sol, s_eol});
        end
        checks++;
        if ({s_data, s_x, s_y, s_addr} !== 52'h0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", {s_data, s_x, s_y, s_addr});
        end
        checks++;
        if ({l_busy, l_rd_en, l_valid, l_addr} !== 15'h0) begin
            errors++;
            $display("FAIL reset_large got %h want 0", {l_busy, l_rd_en, l_valid, l_addr});
        end
        @(posedge clk); #1 s_rst = 1'b0; l_rst = 1'b0;
    endtask

    task automatic test_basic();
        int nb;
        s_clear();
        s_ready = 1'b1;
        s_pulse_start();
        @(negedge clk);
        checks++;
        if (s_busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy got %b want 1", s_busy);
        end
        s_wait_done(200);
        checks++;
        if (s_done_cyc.size() != 1) begin
            errors++;
            $display("FAIL basic_done_count got %0d want 1", s_done_cyc.size());
        end
        checks++;
        if (s_beats.size() != 8) begin
            errors++;
            $display("FAIL basic_beats got %0d want 8", s_beats.size());
        end
        nb = (s_beats.size() < 8) ? s_beats.size() : 8;
        for (int k = 0; k < nb; k++) begin
            checks++;
            if (pack_beat(s_beats[k]) !== exp_beat(4, 2, k)) begin
                errors++;
                $display("FAIL basic_beat%0d got %h want %h", k, pack_beat(s_beats[k]),
                         exp_beat(4, 2, k));
            end
        end
        if (nb == 8 && s_done_cyc.size() > 0) begin
            checks++;
            if (s_done_cyc[0] - s_beats[7].c != 1) begin
                errors++;
                $display("FAIL basic_done_lat got %0d want 1", s_done_cyc[0] - s_beats[7].c);
            end
        end
        checks++;
        if (s_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_end got %b want 0", s_busy);
        end
`ifdef TEST_PATTERN_EN
        checks++;
        if (s_rd_cyc.size() != 0) begin
            errors++;
            $display("FAIL basic_rd_en got %0d reads want 0", s_rd_cyc.size());
        end
`else
        checks++;
        if (s_rd_cyc.size() != 8) begin
            errors++;
            $display("FAIL basic_reads got %0d want 8", s_rd_cyc.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (s_rd_addr[k] != k) begin
                    errors++;
                    $display("FAIL basic_addr%0d got %0d want %0d", k, s_rd_addr[k], k);
                end
            end
            checks++;
            if (s_rd_cyc[4] - s_rd_cyc[3] != 3) begin
                errors++;
                $display("FAIL basic_hblank got %0d want 3", s_rd_cyc[4] - s_rd_cyc[3]);
            end
            if (nb > 0) begin
                checks++;
                if (s_beats[0].c - s_rd_cyc[0] != 2) begin
                    errors++;
                    $display("FAIL basic_latency got %0d want 2", s_beats[0].c - s_rd_cyc[0]);
                end
            end
        end
`endif
    endtask

    task automatic test_stall();
        int n = 0;
        logic [43:0] held;
        s_clear();
        s_ready = 1'b1;
        s_pulse_start();
        while (!(s_valid && s_x == 16'd1 && s_y == 16'd0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1 s_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) held = {s_data, s_x, s_y, s_sol, s_eol, s_sof, s_eof};
            checks++;
            if ({s_valid, s_data, s_x} !== {1'b1, exp_pix(4, 2), 16'd2}) begin
                errors++;
                $display("FAIL stall_head%0d got %h want %h", i, {s_valid, s_data, s_x},
                         {1'b1, exp_pix(4, 2), 16'd2});
            end
            checks++;
            if ({s_data, s_x, s_y, s_sol, s_eol, s_sof, s_eof} !== held) begin
                errors++;
                $display("FAIL stall_hold%0d got %h want %h", i,
                         {s_data, s_x, s_y, s_sol, s_eol, s_sof, s_eof}, held);
            end
            checks++;
            if (s_rd_en !== 1'b0) begin
                errors++;
                $display("FAIL stall_rd%0d got %b want 0", i, s_rd_en);
            end
        end
        @(posedge clk); #1 s_ready = 1'b1;
        s_wait_done(200);
        checks++;
        if (s_beats.size() != 8) begin
            errors++;
            $display("FAIL stall_beats got %0d want 8", s_beats.size());
        end
        for (int k = 0; k < s_beats.size() && k < 8; k++) begin
            checks++;
            if (pack_beat(s_beats[k]) !== exp_beat(4, 2, k)) begin
                errors++;
                $display("FAIL stall_beat%0d got %h want %h", k, pack_beat(s_beats[k]),
                         exp_beat(4, 2, k));
            end
        end
        checks++;
        if (s_done_cyc.size() != 1) begin
            errors++;
            $display("FAIL stall_done got %0d want 1", s_done_cyc.size());
        end
    endtask

    task automatic test_start_mid();
        int bad = 0;
        s_clear();
        s_ready = 1'b1;
        s_pulse_start();
        repeat (4) @(posedge clk);
        s_pulse_start();
        s_wait_done(200);
        repeat (10) @(negedge clk);
        checks++;
        if (s_beats.size() != 8) begin
            errors++;
            $display("FAIL restart_beats got %0d want 8", s_beats.size());
        end
        for (int k = 0; k < s_beats.size() && k < 8; k++)
            if (pack_beat(s_beats[k]) !== exp_beat(4, 2, k)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL restart_seq got %0d bad beats want 0", bad);
        end
        checks++;
        if (s_done_cyc.size() != 1 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_done got %0d/%b want 1/0", s_done_cyc.size(), s_busy);
        end
    endtask

    task automatic test_rst_mid();
        int n = 0;
        s_clear();
        s_ready = 1'b1;
        s_pulse_start();
        while (!(s_valid && s_x == 16'd1 && s_y == 16'd1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1 s_rst = 1'b1;
        @(posedge clk); #1 s_rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_valid, s_busy, s_rd_en} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_outs got %b want 000", {s_valid, s_busy, s_rd_en});
        end
        repeat (3) @(negedge clk);
        s_clear();
        s_pulse_start();
        s_wait_done(200);
        checks++;
        if (s_beats.size() != 8) begin
            errors++;
            $display("FAIL rstmid_beats got %0d want 8", s_beats.size());
        end
        if (s_beats.size() > 0) begin
            checks++;
            if (pack_beat(s_beats[0]) !== exp_beat(4, 2, 0)) begin
                errors++;
                $display("FAIL rstmid_first got %h want %h", pack_beat(s_beats[0]),
                         exp_beat(4, 2, 0));
            end
        end
`ifndef TEST_PATTERN_EN
        checks++;
        if (s_rd_addr.size() == 0 || s_rd_addr[0] != 0) begin
            errors++;
            $display("FAIL rstmid_addr got %0d reads first %0d want addr 0", s_rd_addr.size(),
                     (s_rd_addr.size() > 0) ? s_rd_addr[0] : -1);
        end
`endif
    endtask

    task automatic test_random_large();
        int n = 0;
        int bad = 0;
        l_beats.delete();
        l_done_n = 0;
        l_hold_viol = 0;
        l_ready = 1'b1;
        @(posedge clk); #1 l_start = 1'b1;
        @(posedge clk); #1 l_start = 1'b0;
        while (l_done_n == 0 && n < 30000) begin
            @(posedge clk); #1 l_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        l_ready = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (l_beats.size() != 3072) begin
            errors++;
            $display("FAIL random_beats got %0d want 3072", l_beats.size());
        end
        for (int k = 0; k < l_beats.size() && k < 3072; k++) begin
            checks++;
            if (pack_beat(l_beats[k]) !== exp_beat(64, 48, k)) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random_beat%0d got %h want %h", k, pack_beat(l_beats[k]),
                             exp_beat(64, 48, k));
            end
        end
        checks++;
        if (l_done_n != 1) begin
            errors++;
            $display("FAIL random_done got %0d want 1", l_done_n);
        end
        checks++;
        if (l_hold_viol != 0) begin
            errors++;
            $display("FAIL random_hold got %0d violations want 0", l_hold_viol);
        end
    endtask

    initial begin
        s_rst = 1'b1; s_start = 1'b0; s_ready = 1'b1;
        l_rst = 1'b1; l_start = 1'b0; l_ready = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_start_mid();
        test_rst_mid();
        test_random_large();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
